// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential EX-stage ALU.
//   - 6-bit function codes accepted on alu_seq.op
//   - FSM state encoding for alu_seq
//   - is_branch() helper that classifies the condition-evaluation codes
package alu_pkg;

    localparam logic [5:0] OP_ADD    = 6'b100000;
    localparam logic [5:0] OP_ADDU   = 6'b100001;
    localparam logic [5:0] OP_SUB    = 6'b100010;
    localparam logic [5:0] OP_SUBU   = 6'b100011;
    localparam logic [5:0] OP_AND    = 6'b100100;
    localparam logic [5:0] OP_OR     = 6'b100101;
    localparam logic [5:0] OP_XOR    = 6'b100110;
    localparam logic [5:0] OP_NOR    = 6'b100111;
    localparam logic [5:0] OP_SLT    = 6'b101010;
    localparam logic [5:0] OP_SLTU   = 6'b101011;
    localparam logic [5:0] OP_SLL    = 6'b000000;
    localparam logic [5:0] OP_SRL    = 6'b000010;
    localparam logic [5:0] OP_SRA    = 6'b000011;
    localparam logic [5:0] OP_SLLV   = 6'b000100;
    localparam logic [5:0] OP_SRLV   = 6'b000110;
    localparam logic [5:0] OP_SRAV   = 6'b000111;
    localparam logic [5:0] OP_MOVZ   = 6'b001010;
    localparam logic [5:0] OP_MOVN   = 6'b001011;
    localparam logic [5:0] OP_MOV    = 6'b111111;
    localparam logic [5:0] OP_CLO    = 6'b011100;
    localparam logic [5:0] OP_CLZ    = 6'b011101;
    localparam logic [5:0] OP_MULTU  = 6'b011001;
    localparam logic [5:0] OP_ALWAYS = 6'b011111;
    localparam logic [5:0] OP_EQZ    = 6'b011011;
    localparam logic [5:0] OP_GT     = 6'b001111;
    localparam logic [5:0] OP_GTZ    = 6'b001101;
    localparam logic [5:0] OP_LEZ    = 6'b010011;
    localparam logic [5:0] OP_LT     = 6'b110111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_MUL   = 2'd2
    } state_e;

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_ALWAYS) || (op == OP_EQZ) || (op == OP_GT) ||
               (op == OP_GTZ)    || (op == OP_LEZ) || (op == OP_LT);
    endfunction

endpackage

// File: rtl/alu_seq_multu.sv
// alu_seq_multu: iterative unsigned shift-add multiplier, one multiplier bit
// per clock, WIDTH iterations.
// Ports:
//   clk, reset        clock, synchronous active-high reset (aborts a product)
//   start_i           load a_i/b_i and begin; ignored while an op is running
//   a_i, b_i          multiplicand / multiplier
//   done_o            high during the final iteration cycle
//   product_o         full 2*WIDTH product, valid while done_o=1
module alu_seq_multu #(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    logic                 busy_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     mcand_q;
    // Upper half accumulates partial sums; lower half starts as the multiplier
    // and is consumed LSB-first as the whole register shifts right.
    logic [2*WIDTH-1:0]   prod_q;
    logic [2*WIDTH-1:0]   prod_d;
    logic [WIDTH:0]       sum;

    always_comb begin
        sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d = {sum, prod_q[WIDTH-1:1]};
    end

    // Done is combinational so the parent can register the product on the
    // same edge that retires the last iteration.
    assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign product_o = prod_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
        end else if (start_i && !busy_q) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            mcand_q <= a_i;
            prod_q  <= {{WIDTH{1'b0}}, b_i};
        end else if (busy_q) begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q + CW'(1);
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle EX-stage ALU with start/busy/done handshake.
// Single-cycle ops finish one clock after start; CLO/CLZ iterate one bit per
// clock; MULTU uses the alu_seq_multu sub-block (WIDTH iterations).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, op, a, b, shamt request, function code, operands, shift amount
//   busy                  iterative op in progress (start ignored)
//   done                  one-cycle pulse; registered outputs updated
//   result, result_hi     result / product halves (result_hi only for MULTU)
//   wr_en, condition      destination write enable, branch outcome
//   zero/negative/carry/overflow_flag, illegal_op   status
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  bit MUL_EN = 1'b1,
    localparam int SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             wr_en,
    output logic             condition,
    output logic             zero_flag,
    output logic             negative_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             illegal_op
);

    localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(WIDTH - 1);
    localparam int           M        = WIDTH - 1;

    state_e           state_q;
    logic             busy_q, done_q, wr_q, cond_q, zero_q, neg_q, carry_q, ovf_q, ill_q;
    logic [WIDTH-1:0] result_q, result_hi_q;

    // Single-cycle datapath
    logic [WIDTH-1:0] res_d;
    logic             wr_d, cond_d, carry_d, ovf_d, ill_d, branch_d;
    logic [WIDTH:0]   add_ext, sub_ext;
    logic [SHW-1:0]   vsh;

    always_comb begin
        res_d    = '0;
        wr_d     = 1'b1;
        cond_d   = 1'b0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        ill_d    = 1'b0;
        branch_d = is_branch(op);
        vsh      = a[SHW-1:0];
        add_ext  = {1'b0, a} + {1'b0, b};
        // MSB of the extended difference is the unsigned borrow (a < b).
        sub_ext  = {1'b0, a} - {1'b0, b};
        case (op)
            OP_ADD: begin
                res_d = add_ext[M:0];
                ovf_d = (a[M] == b[M]) && (res_d[M] != a[M]);
            end
            OP_ADDU: begin
                res_d   = add_ext[M:0];
                carry_d = add_ext[WIDTH];
            end
            OP_SUB: begin
                res_d = sub_ext[M:0];
                ovf_d = (a[M] != b[M]) && (res_d[M] != a[M]);
            end
            OP_SUBU: begin
                res_d   = sub_ext[M:0];
                carry_d = sub_ext[WIDTH];
            end
            OP_AND:    res_d = a & b;
            OP_OR:     res_d = a | b;
            OP_XOR:    res_d = a ^ b;
            OP_NOR:    res_d = ~(a | b);
            OP_SLT:    res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:   res_d = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:    res_d = b << shamt;
            OP_SRL:    res_d = b >> shamt;
            OP_SRA:    res_d = $signed(b) >>> shamt;
            OP_SLLV:   res_d = b << vsh;
            OP_SRLV:   res_d = b >> vsh;
            OP_SRAV:   res_d = $signed(b) >>> vsh;
            OP_MOV:    res_d = a;
            OP_MOVN: begin
                res_d = a;
                wr_d  = (b != '0);
            end
            OP_MOVZ: begin
                res_d = a;
                wr_d  = (b == '0);
            end
            OP_ALWAYS: cond_d = 1'b1;
            OP_EQZ:    cond_d = (a == '0);
            OP_GTZ:    cond_d = ($signed(a) > 0);
            OP_LEZ:    cond_d = ($signed(a) <= 0);
            OP_GT:     cond_d = ($signed(a) > $signed(b));
            OP_LT:     cond_d = ($signed(a) < $signed(b));
            OP_CLO, OP_CLZ: ill_d = 1'b0;
            OP_MULTU: begin
                ill_d = !MUL_EN;
                wr_d  = MUL_EN;
            end
            default: begin
                ill_d = 1'b1;
                wr_d  = 1'b0;
            end
        endcase
        if (branch_d) begin
            wr_d = 1'b0;
        end
    end

    // Leading-bit counter
    logic [WIDTH-1:0] sh_q;
    logic [SHW:0]     cnt_q;
    logic             tgt_q;
    logic             cnt_hit, cnt_fin;
    logic [SHW:0]     cnt_val;
    logic [WIDTH-1:0] cnt_res;

    always_comb begin
        cnt_hit = (sh_q[M] == tgt_q);
        // A hit on the last bit position makes the count reach WIDTH.
        cnt_fin = !cnt_hit || (cnt_q == CNT_LAST);
        cnt_val = cnt_hit ? (cnt_q + (SHW + 1)'(1)) : cnt_q;
        cnt_res = {{(WIDTH-SHW-1){1'b0}}, cnt_val};
    end

    // Multiplier
    logic                 mul_start, mul_done;
    logic [2*WIDTH-1:0]   mul_prod;

    assign mul_start = (state_q == S_IDLE) && start && (op == OP_MULTU);

    generate
        if (MUL_EN) begin : g_mul
            alu_seq_multu #(.WIDTH(WIDTH)) u_multu (
                .clk       (clk),
                .reset     (reset),
                .start_i   (mul_start),
                .a_i       (a),
                .b_i       (b),
                .done_o    (mul_done),
                .product_o (mul_prod)
            );
        end else begin : g_nomul
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            wr_q        <= 1'b0;
            cond_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_CLO || op == OP_CLZ) begin
                            state_q <= S_COUNT;
                            busy_q  <= 1'b1;
                            sh_q    <= a;
                            cnt_q   <= '0;
                            tgt_q   <= (op == OP_CLO);
                        end else if (op == OP_MULTU && MUL_EN) begin
                            state_q <= S_MUL;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q      <= 1'b1;
                            result_q    <= res_d;
                            result_hi_q <= '0;
                            wr_q        <= wr_d;
                            cond_q      <= cond_d;
                            zero_q      <= !branch_d && (res_d == '0);
                            neg_q       <= !branch_d && res_d[M];
                            carry_q     <= carry_d;
                            ovf_q       <= ovf_d;
                            ill_q       <= ill_d;
                        end
                    end
                end
                S_COUNT: begin
                    if (cnt_fin) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        result_q    <= cnt_res;
                        result_hi_q <= '0;
                        wr_q        <= 1'b1;
                        cond_q      <= 1'b0;
                        zero_q      <= (cnt_res == '0);
                        neg_q       <= cnt_res[M];
                        carry_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                        ill_q       <= 1'b0;
                    end else begin
                        cnt_q <= cnt_val;
                        sh_q  <= sh_q << 1;
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        result_q    <= mul_prod[WIDTH-1:0];
                        result_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
                        wr_q        <= 1'b1;
                        cond_q      <= 1'b0;
                        zero_q      <= 1'b0;
                        neg_q       <= 1'b0;
                        carry_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                        ill_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign result        = result_q;
    assign result_hi     = result_hi_q;
    assign wr_en         = wr_q;
    assign condition     = cond_q;
    assign zero_flag     = zero_q;
    assign negative_flag = neg_q;
    assign carry_flag    = carry_q;
    assign overflow_flag = ovf_q;
    assign illegal_op    = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=32, MUL_EN=1).
// The driver pushes the expected response of every accepted request; the
// monitor pops and compares on each done pulse, including the done cycle.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0]  shamt = '0;
    logic        busy, done, wr_en, condition;
    logic        zero_flag, negative_flag, carry_flag, overflow_flag, illegal_op;
    logic [31:0] result, result_hi;

    alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .shamt(shamt), .busy(busy), .done(done), .result(result),
        .result_hi(result_hi), .wr_en(wr_en), .condition(condition),
        .zero_flag(zero_flag), .negative_flag(negative_flag),
        .carry_flag(carry_flag), .overflow_flag(overflow_flag),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] res, hi;
        bit wr, cond, z, n, c, v, ill, chk_zn;
        int lat, iss_cyc, exp_cyc;
    } exp_t;

    exp_t sbq[$];

    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    localparam logic [5:0] SINGLES [25] = '{
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
        OP_MOVZ, OP_MOVN, OP_MOV, OP_ALWAYS, OP_EQZ, OP_GT, OP_GTZ, OP_LEZ, OP_LT
    };

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model: arithmetic on plain integers, counts by scanning bits.
    function automatic exp_t model(input logic [5:0] o, input logic [31:0] x,
                                   input logic [31:0] y, input logic [4:0] s);
        exp_t e;
        int sx, sy, n;
        longint ls;
        logic [63:0] lu;
        bit br, tgt;
        sx = x; sy = y; br = 0;
        e.op = o; e.res = 0; e.hi = 0; e.wr = 1; e.cond = 0; e.z = 0; e.n = 0;
        e.c = 0; e.v = 0; e.ill = 0; e.chk_zn = 1; e.lat = 1; e.iss_cyc = 0; e.exp_cyc = 0;
        case (o)
            OP_ADD:  begin ls = longint'(sx) + longint'(sy); e.res = ls[31:0]; e.v = (ls > SMAX) || (ls < SMIN); end
            OP_SUB:  begin ls = longint'(sx) - longint'(sy); e.res = ls[31:0]; e.v = (ls > SMAX) || (ls < SMIN); end
            OP_ADDU: begin lu = {32'h0, x} + {32'h0, y}; e.res = lu[31:0]; e.c = (lu > 64'hFFFF_FFFF); end
            OP_SUBU: begin e.res = x - y; e.c = (x < y); end
            OP_AND:  e.res = x & y;
            OP_OR:   e.res = x | y;
            OP_XOR:  e.res = x ^ y;
            OP_NOR:  e.res = ~(x | y);
            OP_SLT:  e.res = (sx < sy) ? 1 : 0;
            OP_SLTU: e.res = (x < y) ? 1 : 0;
            OP_SLL:  e.res = y << s;
            OP_SRL:  e.res = y >> s;
            OP_SRA:  e.res = sy >>> s;
            OP_SLLV: e.res = y << x[4:0];
            OP_SRLV: e.res = y >> x[4:0];
            OP_SRAV: e.res = sy >>> x[4:0];
            OP_MOV:  e.res = x;
            OP_MOVN: begin e.res = x; e.wr = (y != 0); end
            OP_MOVZ: begin e.res = x; e.wr = (y == 0); end
            OP_CLO, OP_CLZ: begin
                tgt = (o == OP_CLO);
                n = 0;
                while (n < 32 && x[31-n] == tgt) n++;
                e.res = n;
                e.lat = ((n + 1 < 32) ? n + 1 : 32) + 1;
            end
            OP_MULTU: begin
                lu = {32'h0, x} * {32'h0, y};
                e.res = lu[31:0]; e.hi = lu[63:32]; e.lat = 33;
            end
            OP_ALWAYS: begin br = 1; e.cond = 1; end
            OP_EQZ:    begin br = 1; e.cond = (x == 0); end
            OP_GTZ:    begin br = 1; e.cond = (sx > 0); end
            OP_LEZ:    begin br = 1; e.cond = (sx <= 0); end
            OP_GT:     begin br = 1; e.cond = (sx > sy); end
            OP_LT:     begin br = 1; e.cond = (sx < sy); end
            default:   begin e.ill = 1; e.wr = 0; end
        endcase
        if (br) begin e.wr = 0; e.chk_zn = 0; end
        else if (o != OP_MULTU) begin e.z = (e.res == 0); e.n = e.res[31]; end
        return e;
    endfunction

    // Monitor
    bit           mon_en = 0;
    bit           prev_valid = 0;
    bit           reset_prev = 0;
    logic [70:0]  prev_bus;
    logic [70:0]  obus;
    assign obus = {result_hi, result, wr_en, condition, zero_flag, negative_flag,
                   carry_flag, overflow_flag, illegal_op};

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("done_cycle op=%b", e.op), cyc, e.exp_cyc);
                    chk($sformatf("result op=%b", e.op), result, e.res);
                    chk($sformatf("result_hi op=%b", e.op), result_hi, e.hi);
                    chk($sformatf("wr_en op=%b", e.op), wr_en, e.wr);
                    chk($sformatf("condition op=%b", e.op), condition, e.cond);
                    chk($sformatf("carry op=%b", e.op), carry_flag, e.c);
                    chk($sformatf("overflow op=%b", e.op), overflow_flag, e.v);
                    chk($sformatf("illegal op=%b", e.op), illegal_op, e.ill);
                    chk($sformatf("busy_at_done op=%b", e.op), busy, 0);
                    if (e.chk_zn) begin
                        chk($sformatf("zero op=%b", e.op), zero_flag, e.z);
                        chk($sformatf("negative op=%b", e.op), negative_flag, e.n);
                    end
                end
            end else begin
                if (sbq.size() > 0 && cyc > sbq[0].exp_cyc) begin
                    chk($sformatf("done_timeout op=%b", sbq[0].op), 0, 1);
                    void'(sbq.pop_front());
                end else if (sbq.size() > 0 && sbq[0].lat > 1 &&
                             cyc > sbq[0].iss_cyc && cyc < sbq[0].exp_cyc) begin
                    chk($sformatf("busy op=%b", sbq[0].op), busy, 1);
                end
                if (prev_valid && !reset_prev)
                    chk("outputs_hold", obus, prev_bus);
            end
            prev_bus   = obus;
            prev_valid = 1;
        end
        reset_prev = reset;
    end

    // Driver
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_release", busy, 0);
    endtask

    task automatic issue(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] s, input bit wait_done);
        exp_t e;
        op = o; a = x; b = y; shamt = s; start = 1'b1;
        e = model(o, x, y, s);
        e.iss_cyc = cyc;
        e.exp_cyc = cyc + e.lat;
        sbq.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        if (wait_done) wait_idle();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int t0, k, r, nw;
        logic [5:0]  o;
        logic [31:0] x, y, base;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_outputs", obus, 0);
        mon_en = 1;

        // Directed cases
        issue(OP_ADD,  32'h7FFF_FFFF, 32'h1, 0, 1);
        issue(OP_SUBU, 32'h0, 32'h1, 0, 1);
        issue(OP_SLT,  32'hFFFF_FFFF, 32'h1, 0, 1);
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1, 0, 1);
        issue(OP_CLZ,  32'h00F0_0000, 32'h0, 0, 1);
        issue(OP_CLO,  32'hFFFF_FFFF, 32'h0, 0, 1);
        issue(OP_CLO,  32'h0, 32'h0, 0, 1);

        // MULTU with an ignored second start in cycle 5
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 0, 0);
        t0 = cyc - 1;
        while (cyc < t0 + 5) begin @(posedge clk); #1; end
        op = OP_ADD; a = 32'h1; b = 32'h1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        issue(OP_GT,   32'hFFFF_FFFF, 32'h1, 0, 1);
        issue(OP_LEZ,  32'h0, 32'h0, 0, 1);
        issue(OP_MOVZ, 32'h7, 32'h5, 0, 1);
        issue(6'b110000, 32'h12, 32'h34, 0, 1);
        issue(OP_SRA,  32'h0, 32'h8000_00F0, 5'd4, 1);
        issue(OP_SRLV, 32'h24, 32'h8000_00F0, 5'd0, 1);

        // Reset in cycle 5 of a long CLZ aborts it
        issue(OP_CLZ, 32'h1, 32'h0, 0, 0);
        t0 = cyc - 1;
        while (cyc < t0 + 5) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sbq.delete();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_outputs", obus, 0);
        issue(OP_ADD, 32'd2, 32'd3, 0, 1);

        // Randomized traffic, issued back-to-back whenever busy is low
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            x = pick();
            y = pick();
            if (r < 5)       o = 6'($urandom_range(0, 63));
            else if (r < 9)  o = OP_MULTU;
            else if (r < 22) begin
                o = ($urandom_range(0, 1) != 0) ? OP_CLO : OP_CLZ;
                base = $urandom;
                k = $urandom_range(0, 32);
                if (o == OP_CLZ) x = (k == 32) ? 32'h0 : (base >> k);
                else             x = ~((k == 32) ? 32'h0 : ((~base) >> k));
            end
            else o = SINGLES[$urandom_range(0, 24)];
            issue(o, x, y, 5'($urandom), 1);
        end

        nw = 0;
        while (sbq.size() > 0 && nw < 100) begin @(posedge clk); #1; nw++; end
        chk("scoreboard_drained", sbq.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
